// File: rtl/fft_256.sv
// fft_256: 256-point radix-2 decimation-in-time complex FFT, one shared butterfly, in-place memory.
// Optional macro FFT_ROUND_EN: round half-up on the twiddle product and on each stage's >>>1.
module fft_256 #(
  parameter int unsigned DATA_WIDTH = 18,
  parameter int unsigned FFT_SIZE   = 256,
  parameter int unsigned STAGES     = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic signed [DATA_WIDTH-1:0] data_real_i,
  input  logic signed [DATA_WIDTH-1:0] data_imag_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic signed [DATA_WIDTH-1:0] data_real_o,
  output logic signed [DATA_WIDTH-1:0] data_imag_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned Half  = FFT_SIZE / 2;
  localparam int unsigned SumW  = DW + 2;
  localparam int unsigned ProdW = 2 * DW + 1;
  localparam int unsigned StW   = (STAGES > 1) ? $clog2(STAGES) : 1;
  localparam real         Pi    = 3.14159265358979323846;
  localparam real         Scale = 2.0 ** (DW - 2);

`ifdef FFT_ROUND_EN
  localparam logic signed [ProdW-1:0] RndT = ProdW'(1) << (DW - 3);
  localparam logic signed [SumW-1:0]  RndS = SumW'(1);
`else
  localparam logic signed [ProdW-1:0] RndT = '0;
  localparam logic signed [SumW-1:0]  RndS = '0;
`endif

  typedef enum logic [1:0] {StLoad, StCompute, StOutput} state_e;

  function automatic int round_q(input real x);
    round_q = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  function automatic logic [STAGES-1:0] bitrev(input logic [STAGES-1:0] x);
    for (int i = 0; i < STAGES; i++) bitrev[i] = x[STAGES-1-i];
  endfunction

  // Twiddle ROM: W_k = cos(2*pi*k/N) - j*sin(2*pi*k/N), Q2.(DW-2)
  logic signed [DW-1:0] tw_cos [Half];
  logic signed [DW-1:0] tw_sin [Half];
  for (genvar gi = 0; gi < Half; gi++) begin : g_tw
    localparam real Ang = 2.0 * Pi * real'(gi) / real'(FFT_SIZE);
    assign tw_cos[gi] = DW'(round_q($cos(Ang) * Scale));
    assign tw_sin[gi] = DW'(round_q($sin(Ang) * Scale));
  end

  state_e                 state_q, state_d;
  logic [STAGES-1:0]      in_cnt_q, in_cnt_d;
  logic [STAGES-1:0]      out_cnt_q, out_cnt_d;
  logic [StW-1:0]         stage_q, stage_d;
  logic [STAGES-2:0]      bfly_q, bfly_d;
  logic                   load_we, bf_we;

  logic signed [DW-1:0]   mem_re_q [FFT_SIZE];
  logic signed [DW-1:0]   mem_im_q [FFT_SIZE];

  logic [STAGES-1:0]      span, pos, addr_a, addr_b, tw_full;
  logic [STAGES-2:0]      tw_idx;
  logic signed [DW-1:0]   a_re, a_im, b_re, b_im, w_c, w_s;
  logic signed [ProdW-1:0] pr_re, pr_im, sh_re, sh_im;
  logic signed [SumW-1:0] wb_re, wb_im, sa_re, sa_im, sb_re, sb_im;
  logic signed [DW-1:0]   na_re, na_im, nb_re, nb_im;

  // Butterfly j of stage s pairs a = (j >> s) * 2*span + (j mod span) with a + span.
  always_comb begin
    span    = STAGES'(1) << stage_q;
    pos     = {1'b0, bfly_q} & (span - STAGES'(1));
    addr_a  = ((({1'b0, bfly_q}) >> stage_q) << 1 << stage_q) | pos;
    addr_b  = addr_a | span;
    tw_full = pos << (STAGES - 1 - stage_q);
    tw_idx  = tw_full[STAGES-2:0];

    a_re = mem_re_q[addr_a];
    a_im = mem_im_q[addr_a];
    b_re = mem_re_q[addr_b];
    b_im = mem_im_q[addr_b];
    w_c  = tw_cos[tw_idx];
    w_s  = tw_sin[tw_idx];

    // (c - j s)(br + j bi) = (c*br + s*bi) + j(c*bi - s*br)
    pr_re = ProdW'(w_c) * ProdW'(b_re) + ProdW'(w_s) * ProdW'(b_im) + RndT;
    pr_im = ProdW'(w_c) * ProdW'(b_im) - ProdW'(w_s) * ProdW'(b_re) + RndT;
    sh_re = pr_re >>> (DW - 2);
    sh_im = pr_im >>> (DW - 2);
    wb_re = sh_re[SumW-1:0];
    wb_im = sh_im[SumW-1:0];

    sa_re = SumW'(a_re) + wb_re + RndS;
    sa_im = SumW'(a_im) + wb_im + RndS;
    sb_re = SumW'(a_re) - wb_re + RndS;
    sb_im = SumW'(a_im) - wb_im + RndS;
    na_re = DW'(sa_re >>> 1);
    na_im = DW'(sa_im >>> 1);
    nb_re = DW'(sb_re >>> 1);
    nb_im = DW'(sb_im >>> 1);
  end

  always_comb begin
    state_d   = state_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    stage_d   = stage_q;
    bfly_d    = bfly_q;
    load_we   = 1'b0;
    bf_we     = 1'b0;
    unique case (state_q)
      StLoad: begin
        if (valid_i) begin
          load_we  = 1'b1;
          in_cnt_d = in_cnt_q + STAGES'(1);
          if (in_cnt_q == STAGES'(FFT_SIZE - 1)) state_d = StCompute;
        end
      end
      StCompute: begin
        bf_we  = 1'b1;
        bfly_d = bfly_q + (STAGES-1)'(1);
        if (bfly_q == '1) begin
          stage_d = stage_q + StW'(1);
          if (stage_q == StW'(STAGES - 1)) begin
            stage_d = '0;
            state_d = StOutput;
          end
        end
      end
      StOutput: begin
        if (ready_i) begin
          out_cnt_d = out_cnt_q + STAGES'(1);
          if (out_cnt_q == STAGES'(FFT_SIZE - 1)) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StLoad;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      stage_q   <= '0;
      bfly_q    <= '0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      stage_q   <= stage_d;
      bfly_q    <= bfly_d;
    end
  end

  // Sample memory is deliberately left uncleared by reset.
  always_ff @(posedge clk_i) begin
    if (load_we) begin
      mem_re_q[bitrev(in_cnt_q)] <= data_real_i;
      mem_im_q[bitrev(in_cnt_q)] <= data_imag_i;
    end else if (bf_we) begin
      mem_re_q[addr_a] <= na_re;
      mem_im_q[addr_a] <= na_im;
      mem_re_q[addr_b] <= nb_re;
      mem_im_q[addr_b] <= nb_im;
    end
  end

  assign ready_o     = (state_q == StLoad);
  assign busy_o      = (state_q != StLoad);
  assign valid_o     = (state_q == StOutput);
  assign data_real_o = valid_o ? mem_re_q[out_cnt_q] : '0;
  assign data_imag_o = valid_o ? mem_im_q[out_cnt_q] : '0;

endmodule

// File: tb/tb_fft_256.sv
// tb_fft_256: frame-level bench for fft_256 against a direct floating-point DFT (scaled by 1/N).
module tb_fft_256;

  localparam int  N  = 256;
  localparam int  DW = 18;
  localparam real Pi = 3.14159265358979323846;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic signed [DW-1:0] data_real_i, data_imag_i;
  logic                 valid_i;
  logic                 ready_o;
  logic signed [DW-1:0] data_real_o, data_imag_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 busy_o;

  always #5 clk_i = ~clk_i;

  fft_256 #(.DATA_WIDTH(DW), .FFT_SIZE(N), .STAGES(8)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .data_real_i(data_real_i),
    .data_imag_i(data_imag_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .data_real_o(data_real_o),
    .data_imag_o(data_imag_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .busy_o     (busy_o)
  );

  typedef struct {
    int frame;
    int bin;
    int exp_re;
    int exp_im;
    int tol;
  } vec_t;

  vec_t tbl [11];
  int   n_vec = 0;
  int   n_err = 0;
  int   in_re [N], in_im [N];
  int   got_re[N], got_im[N];
  int   sav_re[N], sav_im[N];
  real  ref_re[N], ref_im[N];

  function automatic int rnd(input real x);
    rnd = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
  endfunction

  task automatic chk(input string name, input int idx, input real act, input real exp,
                     input real tol);
    real d;
    d = act - exp;
    if (d < 0.0) d = -d;
    n_vec++;
    if (d > tol) begin
      n_err++;
      $display("FAIL %s [%0d]: got %0.2f, expected %0.2f (tol %0.1f)", name, idx, act, exp, tol);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic build_frame(input int kind);
    for (int n = 0; n < N; n++) begin
      real t16, t64;
      t16 = 2.0 * Pi * 16.0 * real'(n) / real'(N);
      t64 = 2.0 * Pi * 64.0 * real'(n) / real'(N);
      in_im[n] = 0;
      case (kind)
        0:       in_re[n] = rnd(32767.0 * $sin(t16));
        1:       in_re[n] = 65535;
        2:       in_re[n] = rnd(16383.0 * $sin(t16) + 16383.0 * $sin(t64));
        default: begin
          in_re[n] = int'($urandom_range(0, 32767)) - 16384;
          in_im[n] = int'($urandom_range(0, 32767)) - 16384;
        end
      endcase
    end
  endtask

  // X[k] = (1/N) * sum_n x[n] * exp(-j*2*pi*k*n/N)
  task automatic compute_ref();
    real ct [N];
    real st [N];
    for (int i = 0; i < N; i++) begin
      ct[i] = $cos(2.0 * Pi * real'(i) / real'(N));
      st[i] = $sin(2.0 * Pi * real'(i) / real'(N));
    end
    for (int k = 0; k < N; k++) begin
      real sr, si;
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < N; n++) begin
        int idx;
        idx = (k * n) % N;
        sr += real'(in_re[n]) * ct[idx] + real'(in_im[n]) * st[idx];
        si += real'(in_im[n]) * ct[idx] - real'(in_re[n]) * st[idx];
      end
      ref_re[k] = sr / real'(N);
      ref_im[k] = si / real'(N);
    end
  endtask

  task automatic load_frame(input bit thr);
    int n = 0;
    int guard = 0;
    bit fire;
    while (n < N && guard < 5000) begin
      valid_i     = thr ? ($urandom_range(0, 2) != 0) : 1'b1;
      data_real_i = DW'(in_re[n]);
      data_imag_i = DW'(in_im[n]);
      chk_bit("load_ready", ready_o, 1'b1);
      fire = valid_i && ready_o;
      @(posedge clk_i);
      #1;
      if (fire) n++;
      guard++;
    end
    valid_i = 1'b0;
    if (n < N) chk("load_timeout", n, real'(n), real'(N), 0.0);
    chk_bit("busy_after_load", busy_o, 1'b1);
    chk_bit("ready_after_load", ready_o, 1'b0);
  endtask

  task automatic collect(input bit thr);
    int k = 0;
    int guard = 0;
    int wait_cyc = 0;
    bit holding = 1'b0;
    int h_re = 0;
    int h_im = 0;
    while (k < N && guard < 40000) begin
      ready_i = thr ? 1'($urandom_range(0, 1)) : 1'b1;
      chk_bit("ready_vs_busy", ready_o, !busy_o);
      if (!valid_o) begin
        if (k == 0) wait_cyc++;
      end else begin
        if (holding) begin
          chk("hold_re", k, real'(data_real_o), real'(h_re), 0.0);
          chk("hold_im", k, real'(data_imag_o), real'(h_im), 0.0);
        end
        if (ready_i) begin
          got_re[k] = data_real_o;
          got_im[k] = data_imag_o;
          k++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          h_re    = data_real_o;
          h_im    = data_imag_o;
        end
      end
      @(posedge clk_i);
      #1;
      guard++;
    end
    ready_i = 1'b0;
    if (k < N) chk("output_timeout", k, real'(k), real'(N), 0.0);
    chk("compute_cycles", 0, real'(wait_cyc), 1024.0, 64.0);
    chk_bit("valid_after_frame", valid_o, 1'b0);
    chk_bit("busy_after_frame", busy_o, 1'b0);
    chk_bit("ready_after_frame", ready_o, 1'b1);
  endtask

  task automatic compare_model(input string name, input real tol);
    for (int k = 0; k < N; k++) begin
      chk({name, "_re"}, k, real'(got_re[k]), ref_re[k], tol);
      chk({name, "_im"}, k, real'(got_im[k]), ref_im[k], tol);
    end
  endtask

  initial begin
    tbl[0]  = '{0, 16, 0, -16384, 16};
    tbl[1]  = '{0, 240, 0, 16384, 16};
    tbl[2]  = '{0, 100, 0, 0, 16};
    tbl[3]  = '{1, 0, 65535, 0, 8};
    tbl[4]  = '{1, 1, 0, 0, 8};
    tbl[5]  = '{1, 128, 0, 0, 8};
    tbl[6]  = '{2, 16, 0, -8192, 16};
    tbl[7]  = '{2, 64, 0, -8192, 16};
    tbl[8]  = '{2, 192, 0, 8192, 16};
    tbl[9]  = '{2, 240, 0, 8192, 16};
    tbl[10] = '{2, 32, 0, 0, 16};

    rst_ni      = 1'b0;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    data_real_i = '0;
    data_imag_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_bit("rst_ready", ready_o, 1'b1);
    chk_bit("rst_valid", valid_o, 1'b0);
    chk_bit("rst_busy", busy_o, 1'b0);
    chk("rst_data_re", 0, real'(data_real_o), 0.0, 0.0);
    chk("rst_data_im", 0, real'(data_imag_o), 0.0, 0.0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Deterministic frames: sine, DC, two-tone
    for (int f = 0; f < 3; f++) begin
      build_frame(f);
      compute_ref();
      load_frame(1'b0);
      collect(1'b0);
      compare_model("model", (f == 1) ? 8.0 : 16.0);
      for (int i = 0; i < 11; i++) begin
        if (tbl[i].frame == f) begin
          chk("tbl_re", tbl[i].bin, real'(got_re[tbl[i].bin]), real'(tbl[i].exp_re),
              real'(tbl[i].tol));
          chk("tbl_im", tbl[i].bin, real'(got_im[tbl[i].bin]), real'(tbl[i].exp_im),
              real'(tbl[i].tol));
        end
      end
    end

    // Random frame, unthrottled then throttled: results must be identical
    build_frame(3);
    compute_ref();
    load_frame(1'b0);
    collect(1'b0);
    compare_model("rand", 16.0);
    for (int k = 0; k < N; k++) begin
      sav_re[k] = got_re[k];
      sav_im[k] = got_im[k];
    end
    load_frame(1'b1);
    collect(1'b1);
    for (int k = 0; k < N; k++) begin
      chk("throttle_re", k, real'(got_re[k]), real'(sav_re[k]), 0.0);
      chk("throttle_im", k, real'(got_im[k]), real'(sav_im[k]), 0.0);
    end

    // Reset in the middle of COMPUTE, then a clean DC frame
    build_frame(1);
    compute_ref();
    load_frame(1'b0);
    repeat (100) @(posedge clk_i);
    #1;
    chk_bit("midcomp_busy", busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_bit("midrst_ready", ready_o, 1'b1);
    chk_bit("midrst_valid", valid_o, 1'b0);
    chk_bit("midrst_busy", busy_o, 1'b0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    load_frame(1'b0);
    collect(1'b0);
    compare_model("dc_after_rst", 8.0);
    chk("dc_after_rst_bin0", 0, real'(got_re[0]), 65535.0, 8.0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
